hamming_secded_counter_scrub: RTL and testbench
===============================================

Name: hamming_secded_counter_scrub

Overview:
- Parametrised up-counter whose value is held only as per-nibble SEC-DED codewords: Hamming(7,4) plus an overall parity bit, 8 bits per 4-bit block.
- On increment, the stored word is decoded, corrected, incremented and re-encoded.
- While idle, a scrub FSM periodically checks, corrects and writes back the stored word. It counts corrected and uncorrectable events and freezes on a double error.
- Successor to the single-block Hamming counter. Used wherever the team needs an SEU-tolerant counter of arbitrary width.

Parameters:
- WIDTH, 8, counter width in bits; must be a multiple of 4.
- BLOCKS, WIDTH/4, number of protected nibbles (derived).
- CW_W, BLOCKS*8, stored codeword width (derived).
- SCRUB_PERIOD, 16, idle cycles before a scrub pass; must be >= 2.
- ERR_CNT_W, 8, width of each error event counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  increment request; sampled only when ready=1.
- clear  input  1  synchronous: clears FAULT, error counters and counter value.
- inject_en  input  1  fault injection strobe (test/bench use).
- inject_mask  input  CW_W  bits XORed into the stored codeword when inject_en=1.
- counter  output  WIDTH  corrected (decoded) count; combinational from the stored codeword.
- codeword  output  CW_W  raw stored codeword.
- ready  output  1  1 in RUN state only.
- corr_pulse  output  1  one-cycle pulse when a single-bit correction is committed.
- uncorrectable  output  1  high while in FAULT.
- err_corr_cnt  output  ERR_CNT_W  saturating count of corrected events.
- err_uncorr_cnt  output  ERR_CNT_W  saturating count of uncorrectable events.

Behaviour:
- Block i layout: cw[i*8 +: 8] = {q, p2, p1, p0, d3, d2, d1, d0}.
  - p0 = d0^d2^d3; p1 = d0^d1^d3; p2 = d0^d1^d2.
  - q = XOR of the other 7 bits.
- Syndrome s = {p2,p1,p0}stored ^ recomputed. Overall check k = XOR of all 8 bits.
  - s=0, k=0: clean.
  - s!=0, k=1: single error, correctable. 011 flips d3, 101 flips d2, 110 flips d1, 111 flips d0; 001/010/100 are parity-bit errors (data unchanged).
  - s=0, k=1: q error, correctable.
  - s!=0, k=0: double error, uncorrectable.
- A word is uncorrectable if any block is uncorrectable. It is correctable-with-fix if any block has a single error and none is uncorrectable.
- Reset (reset=0, asynchronous):
  - codeword=0, state=RUN, scrub timer=0.
  - Both error counters 0, corr_pulse=0, uncorrectable=0.
  - Consequently counter=0 and ready=1.
- States: RUN, CHECK, WRITEBACK, FAULT.
- RUN:
  - enable=1: codeword <= encode(decoded+1 mod 2^WIDTH); scrub timer <= 0.
    - If decode was correctable-with-fix: err_corr_cnt++ and corr_pulse=1 the next cycle.
    - If decode was uncorrectable: no write, err_uncorr_cnt++, go to FAULT.
  - enable=0: scrub timer++. When timer = SCRUB_PERIOD-1, go to CHECK and clear the timer.
- CHECK (1 cycle):
  - Register per-block decode results and the corrected word.
  - Go to WRITEBACK if correctable or clean; go to FAULT if uncorrectable (err_uncorr_cnt++).
- WRITEBACK (1 cycle):
  - codeword <= encode(corrected word). The written value is identical if clean.
  - If a fix occurred: err_corr_cnt++ and corr_pulse=1.
  - Go to RUN.
- FAULT:
  - codeword frozen, uncorrectable=1, enable ignored, scrubbing suspended.
- clear=1:
  - Highest priority over all state behaviour.
  - Next cycle: state=RUN, codeword=0, both counters 0, timer 0, corr_pulse=0.
- enable while ready=0 (CHECK/WRITEBACK/FAULT) is dropped, not queued.
- Injection:
  - Applied after the cycle's normal update: codeword <= next_codeword ^ inject_mask.
  - Legal in any state. clear overrides injection.
  - Injection in the CHECK cycle is overwritten by WRITEBACK.
- Wrap: all-ones + 1 gives 0; no flag is raised.
- Error counters saturate at 2^ERR_CNT_W-1.
- Multiple corrected blocks in one event increment the counter by 1.

Test Plan:
- Release reset, enable=1 for 10 cycles (WIDTH=8) -> counter=0x0A, codeword=0x005A, err counts 0, ready=1 throughout.
- Preload 0xFF by counting, one more enable -> counter=0x00, codeword=0x0000, no corr_pulse.
- At 0x0A, enable=0, inject_mask=0x0008 (block0 d3) -> counter still reads 0x0A, codeword=0x0052. The 16th idle cycle enters CHECK, then WRITEBACK. Next cycle codeword=0x005A, corr_pulse=1 for exactly one cycle, err_corr_cnt=1.
- At 0x0A, inject_mask=0x0003 then idle 16 cycles -> FAULT, uncorrectable=1, err_uncorr_cnt=1. enable pulses leave codeword unchanged. clear=1 -> RUN, counter=0, uncorrectable=0, counts 0.
- At 0x0A, inject_mask=0x0100 (block1 d0) with enable=1 the same cycle. Next enable -> counter=0x0C (single error silently corrected, not propagated), err_corr_cnt=1.
- ERR_CNT_W=2: 5 corrected scrub events -> err_corr_cnt saturates at 3. Assert reset low during WRITEBACK -> all outputs immediately at reset values.

Source files
------------

// File: rtl/hamming_secded_counter_scrub_if.sv
// Bus bundle for the SEC-DED protected counter: control/injection inputs and
// decoded count, raw codeword and error status outputs.
interface hamming_secded_counter_scrub_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ERR_CNT_W = 8
);
  localparam int unsigned CW_W = (WIDTH / 4) * 8;

  logic                 enable;
  logic                 clear;
  logic                 inject_en;
  logic [CW_W-1:0]      inject_mask;
  logic [WIDTH-1:0]     counter;
  logic [CW_W-1:0]      codeword;
  logic                 ready;
  logic                 corr_pulse;
  logic                 uncorrectable;
  logic [ERR_CNT_W-1:0] err_corr_cnt;
  logic [ERR_CNT_W-1:0] err_uncorr_cnt;

  modport master (
    output enable, clear, inject_en, inject_mask,
    input  counter, codeword, ready, corr_pulse, uncorrectable,
           err_corr_cnt, err_uncorr_cnt
  );

  modport slave (
    input  enable, clear, inject_en, inject_mask,
    output counter, codeword, ready, corr_pulse, uncorrectable,
           err_corr_cnt, err_uncorr_cnt
  );
endinterface

// File: rtl/hamming_secded_counter_scrub.sv
// Up-counter stored only as per-nibble SEC-DED codewords, with an idle-time
// scrubber that corrects single errors and freezes on double errors.
module hamming_secded_counter_scrub #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SCRUB_PERIOD = 16,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input logic                          clk,
  input logic                          reset,
  hamming_secded_counter_scrub_if.slave bus
);
  localparam int unsigned BLOCKS = WIDTH / 4;
  localparam int unsigned CW_W   = BLOCKS * 8;
  localparam int unsigned TMR_W  = $clog2(SCRUB_PERIOD);

  typedef enum logic [1:0] {RUN, CHECK, WRITEBACK, FAULT} state_t;

  state_t               state_q, state_d;
  logic [CW_W-1:0]      cw_q, cw_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [ERR_CNT_W-1:0] ccnt_q, ccnt_d;
  logic [ERR_CNT_W-1:0] ucnt_q, ucnt_d;
  logic                 pulse_q, pulse_d;
  logic [WIDTH-1:0]     chk_word_q, chk_word_d;
  logic                 chk_fix_q, chk_fix_d;

  logic [WIDTH-1:0]     dec_word;
  logic                 any_sgl;
  logic                 any_dbl;

  // Block layout {q, p2, p1, p0, d3, d2, d1, d0}; q makes the byte even parity.
  function automatic logic [7:0] enc_blk(input logic [3:0] d);
    logic [2:0] p;
    p[0] = d[0] ^ d[2] ^ d[3];
    p[1] = d[0] ^ d[1] ^ d[3];
    p[2] = d[0] ^ d[1] ^ d[2];
    return {^{p, d}, p, d};
  endfunction

  function automatic logic [CW_W-1:0] enc_word(input logic [WIDTH-1:0] w);
    logic [CW_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < BLOCKS; i++) c[i*8 +: 8] = enc_blk(w[i*4 +: 4]);
    return c;
  endfunction

  // Returns {double_error, single_error, corrected_data}.
  function automatic logic [5:0] dec_blk(input logic [7:0] c);
    logic [3:0] d;
    logic [2:0] s;
    logic       k;
    d = c[3:0];
    s = c[6:4] ^ {d[0] ^ d[1] ^ d[2], d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3]};
    k = ^c;
    if (k) begin
      case (s)
        3'b011:  d[3] = ~d[3];
        3'b101:  d[2] = ~d[2];
        3'b110:  d[1] = ~d[1];
        3'b111:  d[0] = ~d[0];
        default: ;
      endcase
    end
    return {(s != 3'b000) && !k, k, d};
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Whole-word decode of the stored codeword.
  always_comb begin
    logic [5:0] r;
    dec_word = '0;
    any_sgl  = 1'b0;
    any_dbl  = 1'b0;
    for (int unsigned i = 0; i < BLOCKS; i++) begin
      r                  = dec_blk(cw_q[i*8 +: 8]);
      dec_word[i*4 +: 4] = r[3:0];
      any_sgl            = any_sgl | r[4];
      any_dbl            = any_dbl | r[5];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      cw_q       <= '0;
      tmr_q      <= '0;
      ccnt_q     <= '0;
      ucnt_q     <= '0;
      pulse_q    <= 1'b0;
      chk_word_q <= '0;
      chk_fix_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cw_q       <= cw_d;
      tmr_q      <= tmr_d;
      ccnt_q     <= ccnt_d;
      ucnt_q     <= ucnt_d;
      pulse_q    <= pulse_d;
      chk_word_q <= chk_word_d;
      chk_fix_q  <= chk_fix_d;
    end
  end

  // Next-state logic; injection lands on top of the update, clear beats everything.
  always_comb begin
    state_d    = state_q;
    cw_d       = cw_q;
    tmr_d      = tmr_q;
    ccnt_d     = ccnt_q;
    ucnt_d     = ucnt_q;
    pulse_d    = 1'b0;
    chk_word_d = chk_word_q;
    chk_fix_d  = chk_fix_q;

    case (state_q)
      RUN: begin
        if (bus.enable) begin
          if (any_dbl) begin
            ucnt_d  = sat_inc(ucnt_q);
            state_d = FAULT;
          end else begin
            cw_d  = enc_word(dec_word + WIDTH'(1));
            tmr_d = '0;
            if (any_sgl) begin
              ccnt_d  = sat_inc(ccnt_q);
              pulse_d = 1'b1;
            end
          end
        end else if (tmr_q == TMR_W'(SCRUB_PERIOD - 1)) begin
          tmr_d   = '0;
          state_d = CHECK;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      CHECK: begin
        chk_word_d = dec_word;
        chk_fix_d  = any_sgl;
        if (any_dbl) begin
          ucnt_d  = sat_inc(ucnt_q);
          state_d = FAULT;
        end else begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        cw_d = enc_word(chk_word_q);
        if (chk_fix_q) begin
          ccnt_d  = sat_inc(ccnt_q);
          pulse_d = 1'b1;
        end
        state_d = RUN;
      end
      FAULT:   ;
      default: state_d = RUN;
    endcase

    if (bus.inject_en) cw_d = cw_d ^ bus.inject_mask;

    if (bus.clear) begin
      state_d    = RUN;
      cw_d       = '0;
      tmr_d      = '0;
      ccnt_d     = '0;
      ucnt_d     = '0;
      pulse_d    = 1'b0;
      chk_word_d = '0;
      chk_fix_d  = 1'b0;
    end
  end

  assign bus.counter        = dec_word;
  assign bus.codeword       = cw_q;
  assign bus.ready          = (state_q == RUN);
  assign bus.uncorrectable  = (state_q == FAULT);
  assign bus.corr_pulse     = pulse_q;
  assign bus.err_corr_cnt   = ccnt_q;
  assign bus.err_uncorr_cnt = ucnt_q;
endmodule

// File: tb/tb_hamming_secded_counter_scrub.sv
// Directed bench: per-cycle vector table on an 8-bit instance, plus a
// hand-written saturation / async-reset sequence on a 2-bit-counter instance.
module tb_hamming_secded_counter_scrub;
  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hamming_secded_counter_scrub_if #(.WIDTH(8), .ERR_CNT_W(8)) b1 ();
  hamming_secded_counter_scrub_if #(.WIDTH(8), .ERR_CNT_W(2)) b2 ();

  hamming_secded_counter_scrub #(.WIDTH(8), .SCRUB_PERIOD(16), .ERR_CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  hamming_secded_counter_scrub #(.WIDTH(8), .SCRUB_PERIOD(16), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .bus(b2));

  typedef struct {
    logic        en;
    logic        clr;
    logic        inj;
    logic [15:0] mask;
    logic        chk_cnt;
    logic [7:0]  cnt;
    logic [15:0] cw;
    logic        rdy;
    logic        pulse;
    logic        unc;
    logic [7:0]  ccnt;
    logic [7:0]  ucnt;
    string       tag;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] enc_nib [16];

  function automatic void add(input logic en, input logic clr, input logic inj,
                              input logic [15:0] mask, input logic chk_cnt,
                              input logic [7:0] cnt, input logic [15:0] cw,
                              input logic rdy, input logic pulse, input logic unc,
                              input logic [7:0] ccnt, input logic [7:0] ucnt,
                              input string tag);
    vec_t v;
    v.en = en; v.clr = clr; v.inj = inj; v.mask = mask; v.chk_cnt = chk_cnt;
    v.cnt = cnt; v.cw = cw; v.rdy = rdy; v.pulse = pulse; v.unc = unc;
    v.ccnt = ccnt; v.ucnt = ucnt; v.tag = tag;
    vecs.push_back(v);
  endfunction

  function automatic logic [15:0] cw_of(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {enc_nib[b[7:4]], enc_nib[b[3:0]]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    enc_nib = '{8'h00, 8'h71, 8'hE2, 8'h93, 8'hD4, 8'hA5, 8'h36, 8'h47,
                8'hB8, 8'hC9, 8'h5A, 8'h2B, 8'h6C, 8'h1D, 8'h8E, 8'hFF};

    // Count 1..10.
    for (int v = 1; v <= 10; v++) add(1, 0, 0, 0, 1, 8'(v), cw_of(v), 1, 0, 0, 0, 0, "count");
    // Single error in block0 d3, repaired by the scrubber.
    add(0, 0, 1, 16'h0008, 1, 8'h0A, 16'h0052, 1, 0, 0, 0, 0, "inj_d3");
    for (int k = 2; k <= 15; k++) add(0, 0, 0, 0, 1, 8'h0A, 16'h0052, 1, 0, 0, 0, 0, "idle");
    add(0, 0, 0, 0, 1, 8'h0A, 16'h0052, 0, 0, 0, 0, 0, "enter_check");
    add(0, 0, 0, 0, 1, 8'h0A, 16'h0052, 0, 0, 0, 0, 0, "writeback");
    add(0, 0, 0, 0, 1, 8'h0A, 16'h005A, 1, 1, 0, 1, 0, "scrub_fixed");
    add(0, 0, 0, 0, 1, 8'h0A, 16'h005A, 1, 0, 0, 1, 0, "pulse_drop");
    // Double error in block0 -> FAULT on the scrub pass.
    add(0, 0, 1, 16'h0003, 0, 8'h00, 16'h0059, 1, 0, 0, 1, 0, "inj_dbl");
    for (int k = 3; k <= 15; k++) add(0, 0, 0, 0, 0, 8'h00, 16'h0059, 1, 0, 0, 1, 0, "idle_dbl");
    add(0, 0, 0, 0, 0, 8'h00, 16'h0059, 0, 0, 0, 1, 0, "check_dbl");
    add(0, 0, 0, 0, 0, 8'h00, 16'h0059, 0, 0, 1, 1, 1, "fault");
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0, 8'h00, 16'h0059, 0, 0, 1, 1, 1, "fault_en");
    add(0, 1, 0, 0, 1, 8'h00, 16'h0000, 1, 0, 0, 0, 0, "clear_fault");
    // Error injected alongside an increment is corrected by the next increment.
    for (int v = 1; v <= 10; v++) add(1, 0, 0, 0, 1, 8'(v), cw_of(v), 1, 0, 0, 0, 0, "recount");
    add(1, 0, 1, 16'h0100, 1, 8'h0B, 16'h012B, 1, 0, 0, 0, 0, "inc_inj");
    add(1, 0, 0, 0, 1, 8'h0C, 16'h006C, 1, 1, 0, 1, 0, "inc_fix");
    add(0, 0, 0, 0, 1, 8'h0C, 16'h006C, 1, 0, 0, 1, 0, "inc_fix_idle");
    // Clear overrides injection, then count through the wrap.
    add(0, 1, 1, 16'hFFFF, 1, 8'h00, 16'h0000, 1, 0, 0, 0, 0, "clear_inj");
    for (int v = 1; v <= 255; v++) add(1, 0, 0, 0, 1, 8'(v), cw_of(v), 1, 0, 0, 0, 0, "to_ff");
    add(1, 0, 0, 0, 1, 8'h00, 16'h0000, 1, 0, 0, 0, 0, "wrap");

    reset = 1'b0; reset2 = 1'b0;
    b1.enable = 0; b1.clear = 0; b1.inject_en = 0; b1.inject_mask = '0;
    b2.enable = 0; b2.clear = 0; b2.inject_en = 0; b2.inject_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_counter", 32'(b1.counter), 0);
    chk("rst_codeword", 32'(b1.codeword), 0);
    chk("rst_ready", 32'(b1.ready), 1);
    chk("rst_unc", 32'(b1.uncorrectable), 0);
    chk("rst_pulse", 32'(b1.corr_pulse), 0);
    chk("rst_ccnt", 32'(b1.err_corr_cnt), 0);
    chk("rst_ucnt", 32'(b1.err_uncorr_cnt), 0);
    @(negedge clk);
    reset = 1'b1; reset2 = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      b1.enable = vecs[i].en; b1.clear = vecs[i].clr;
      b1.inject_en = vecs[i].inj; b1.inject_mask = vecs[i].mask;
      @(posedge clk);
      #1;
      if (vecs[i].chk_cnt) chk({vecs[i].tag, "_counter"}, 32'(b1.counter), 32'(vecs[i].cnt));
      chk({vecs[i].tag, "_codeword"}, 32'(b1.codeword), 32'(vecs[i].cw));
      chk({vecs[i].tag, "_ready"}, 32'(b1.ready), 32'(vecs[i].rdy));
      chk({vecs[i].tag, "_pulse"}, 32'(b1.corr_pulse), 32'(vecs[i].pulse));
      chk({vecs[i].tag, "_unc"}, 32'(b1.uncorrectable), 32'(vecs[i].unc));
      chk({vecs[i].tag, "_ccnt"}, 32'(b1.err_corr_cnt), 32'(vecs[i].ccnt));
      chk({vecs[i].tag, "_ucnt"}, 32'(b1.err_uncorr_cnt), 32'(vecs[i].ucnt));
    end
    @(negedge clk);
    b1.enable = 0; b1.clear = 0; b1.inject_en = 0;

    // Saturating corrected-event counter on the ERR_CNT_W=2 instance.
    @(negedge clk);
    b2.clear = 1;
    @(negedge clk);
    b2.clear = 0;
    for (int ev = 1; ev <= 5; ev++) begin
      b2.inject_en = 1; b2.inject_mask = 16'h0001;
      @(negedge clk);
      b2.inject_en = 0;
      chk("sat_inj_cw", 32'(b2.codeword), 32'h0001);
      chk("sat_inj_counter", 32'(b2.counter), 0);
      repeat (15) @(negedge clk);
      chk("sat_check_ready", 32'(b2.ready), 0);
      @(negedge clk);
      chk("sat_wb_ready", 32'(b2.ready), 0);
      @(negedge clk);
      chk("sat_fixed_cw", 32'(b2.codeword), 0);
      chk("sat_pulse", 32'(b2.corr_pulse), 1);
      chk("sat_ccnt", 32'(b2.err_corr_cnt), (ev < 3) ? ev : 3);
    end
    chk("sat_ucnt", 32'(b2.err_uncorr_cnt), 0);

    // Asynchronous reset while in WRITEBACK.
    b2.inject_en = 1; b2.inject_mask = 16'h0001;
    @(negedge clk);
    b2.inject_en = 0;
    repeat (16) @(negedge clk);
    chk("pre_rst_ready", 32'(b2.ready), 0);
    chk("pre_rst_cw", 32'(b2.codeword), 32'h0001);
    #2 reset2 = 1'b0;
    #1;
    chk("arst_cw", 32'(b2.codeword), 0);
    chk("arst_counter", 32'(b2.counter), 0);
    chk("arst_ready", 32'(b2.ready), 1);
    chk("arst_unc", 32'(b2.uncorrectable), 0);
    chk("arst_pulse", 32'(b2.corr_pulse), 0);
    chk("arst_ccnt", 32'(b2.err_corr_cnt), 0);
    chk("arst_ucnt", 32'(b2.err_uncorr_cnt), 0);
    @(posedge clk);
    #1;
    chk("arst_held_cw", 32'(b2.codeword), 0);
    chk("arst_held_pulse", 32'(b2.corr_pulse), 0);
    @(negedge clk);
    reset2 = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
